// File: rtl/alu_pkg.sv
// Purpose: shared ALU opcodes and front-end FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Used by the ALU, its bench and alu_uart_interface.
package alu_pkg;

  // ALU opcodes (low 4 bits of the opcode byte)
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_NOR = 4'b1110;

  // Front-end FSM state encoding
  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    S_WAIT_A  = ST_WAIT_A,
    S_WAIT_B  = ST_WAIT_B,
    S_WAIT_OP = ST_WAIT_OP,
    S_EXEC    = ST_EXEC,
    S_SEND    = ST_SEND,
    S_WAIT_TX = ST_WAIT_TX
  } state_e;

endpackage

// File: rtl/timeout_counter.sv
// Purpose: inter-byte idle counter; flags expiry on the last allowed idle cycle.
// Latency: o_expired is decoded from the registered count (no extra cycle).
// Backpressure: none; i_clear has priority over i_enable.
// Ports: i_clk, i_rst_n (async active-low), i_enable (count this cycle),
//        i_clear (zero the count), o_expired (count == p_timeoutCycles-1 while enabled).
module timeout_counter #(
  parameter int p_timeoutCycles = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  // p_timeoutCycles == 0 disables the timeout; keep at least one bit of state.
  localparam int W = (p_timeoutCycles > 0) ? $clog2(p_timeoutCycles + 1) : 1;
  localparam logic [W-1:0] LAST = (p_timeoutCycles > 0) ? W'(p_timeoutCycles - 1) : '0;

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != LAST)) begin
      // saturate at LAST; the FSM leaves the counting states on expiry anyway
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (p_timeoutCycles > 0) && i_enable && (cnt_q == LAST);

endmodule

// File: rtl/alu_uart_interface.sv
// Purpose: collect A/B/opcode bytes from UART RX, drive the ALU, send result to UART TX.
// Latency: opcode byte at edge k -> result registered at edge k+1 -> o_txStart in cycle k+1..k+2.
// Backpressure: none on RX; bytes arriving while busy are dropped and flag o_overrun.
// Ports: i_clk, i_rst_n (async active-low); i_rxDone/i_rxData from UART RX;
//        i_txDone, o_txStart/o_txData to UART TX; o_A/o_B/o_ALUBitsControl to ALU,
//        i_ALUResult from ALU; status o_busy, o_timeout (pulse), o_overrun (sticky).
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int p_dataLength         = 8,
  parameter int p_operatorsInputSize = 4,
  parameter int p_timeoutCycles      = 1_000_000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_rxDone,
  input  logic [7:0]                      i_rxData,
  input  logic                            i_txDone,
  output logic                            o_txStart,
  output logic [7:0]                      o_txData,
  output logic [p_dataLength-1:0]         o_A,
  output logic [p_dataLength-1:0]         o_B,
  output logic [p_operatorsInputSize-1:0] o_ALUBitsControl,
  input  logic [p_dataLength-1:0]         i_ALUResult,
  output logic                            o_busy,
  output logic                            o_timeout,
  output logic                            o_overrun
);

  state_e                            state_d, state_q;
  logic [p_dataLength-1:0]           a_d, a_q;
  logic [p_dataLength-1:0]           b_d, b_q;
  logic [p_operatorsInputSize-1:0]   op_d, op_q;
  logic [7:0]                        tx_data_d, tx_data_q;
  logic                              timeout_d, timeout_q;
  logic                              overrun_d, overrun_q;

  logic cnt_enable;
  logic cnt_clear;
  logic cnt_expired;

  // Only the low bits of each byte are used; the rest are intentionally ignored.
  logic unused_rx_bits;
  assign unused_rx_bits = ^i_rxData;

  assign cnt_enable = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);

  timeout_counter #(
    .p_timeoutCycles(p_timeoutCycles)
  ) u_timeout_counter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (cnt_enable),
    .i_clear  (cnt_clear),
    .o_expired(cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    timeout_d = 1'b0;
    overrun_d = overrun_q;
    cnt_clear = 1'b0;

    case (state_q)
      S_WAIT_A: begin
        if (i_rxDone) begin
          a_d       = i_rxData[p_dataLength-1:0];
          state_d   = S_WAIT_B;
          cnt_clear = 1'b1;
        end
      end
      S_WAIT_B: begin
        // a byte on the expiry cycle wins over the timeout
        if (i_rxDone) begin
          b_d       = i_rxData[p_dataLength-1:0];
          state_d   = S_WAIT_OP;
          cnt_clear = 1'b1;
        end else if (cnt_expired) begin
          state_d   = S_WAIT_A;
          timeout_d = 1'b1;
        end
      end
      S_WAIT_OP: begin
        if (i_rxDone) begin
          op_d      = i_rxData[p_operatorsInputSize-1:0];
          state_d   = S_EXEC;
          cnt_clear = 1'b1;
        end else if (cnt_expired) begin
          state_d   = S_WAIT_A;
          timeout_d = 1'b1;
        end
      end
      S_EXEC: begin
        // sign-extend the ALU result to a full byte
        tx_data_d = 8'($signed(i_ALUResult));
        state_d   = S_SEND;
        if (i_rxDone) overrun_d = 1'b1;
      end
      S_SEND: begin
        state_d = S_WAIT_TX;
        if (i_rxDone) overrun_d = 1'b1;
      end
      S_WAIT_TX: begin
        if (i_txDone) state_d = S_WAIT_A;
        if (i_rxDone) overrun_d = 1'b1;
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase

    // every (re)entry to or stay in S_WAIT_A starts the next frame with a fresh count
    if (state_d == S_WAIT_A) cnt_clear = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_WAIT_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // decoded from state only, so reset removes o_txStart without a clock
  assign o_txStart        = (state_q == S_SEND);
  assign o_busy           = (state_q == S_EXEC) || (state_q == S_SEND) || (state_q == S_WAIT_TX);
  assign o_txData         = tx_data_q;
  assign o_A              = a_q;
  assign o_B              = b_q;
  assign o_ALUBitsControl = op_q;
  assign o_timeout        = timeout_q;
  assign o_overrun        = overrun_q;

endmodule
